eeg_epoch_feeder: RTL and testbench
===================================

Name: eeg_epoch_feeder

Overview:
- Upstream stage of the accelerator's SoC-facing data input.
- Accepts raw EEG samples from the ADC front-end and buffers them in a small FIFO.
- On each sleep-epoch tick, emits a one-cycle start_eeg_load pulse, then streams exactly one epoch's worth of samples as paced new_eeg_data/eeg pulses.
- Waits for inference_complete before arming for the next epoch.

Parameters:
- DATA_W, 16, width of eeg/adc_data (matches AdcData_t)
- FIFO_DEPTH, 16, sample buffer depth (power of 2, >=2)
- EPOCH_SAMPLES, 3000, samples per sleep epoch (30 s at 100 Hz)
- GAP_CYCLES, 4, minimum idle cycles between successive new_eeg_data pulses (>=1)
- TIMEOUT_CYCLES, 1000000, inference watchdog limit (used only with EEG_FEED_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- adc_valid  in  1  one-cycle strobe: new ADC sample on adc_data
- adc_data  in  DATA_W  ADC sample, two's complement
- adc_ready  out  1  sample would be stored this cycle (informational; ADC is not back-pressured)
- epoch_tick  in  1  one-cycle epoch boundary strobe
- inference_complete  in  1  accelerator done strobe
- start_eeg_load  out  1  one-cycle pulse opening an epoch load
- new_eeg_data  out  1  one-cycle pulse: eeg valid
- eeg  out  DATA_W  sample; holds its value between pulses
- busy  out  1  state != IDLE
- overflow  out  1  sticky: an in-window sample was dropped because the FIFO was full
- epoch_missed  out  1  sticky: epoch_tick arrived while not IDLE
- timeout  out  1  sticky: inference watchdog expired
- samples_sent  out  $clog2(EPOCH_SAMPLES+1)  new_eeg_data pulses issued this epoch

Behaviour:
- Reset (async, rst_n low):
  - All outputs are 0, eeg is 0, state is IDLE.
  - FIFO is emptied; all counters are 0.
  - Reset mid-epoch abandons the epoch: no further pulses are issued.
- FSM states: IDLE, START, STREAM, WAIT_INF.
- IDLE:
  - adc_ready=0; adc_valid is ignored and not counted.
  - epoch_tick -> START on the next edge.
- START (exactly one cycle):
  - start_eeg_load=1.
  - Clears overflow, epoch_missed, timeout, samples_sent, in_count and the gap counter.
  - Moves to STREAM. The accept window opens this cycle.
- Accept window (START or STREAM, and in_count < EPOCH_SAMPLES):
  - Each adc_valid increments in_count.
  - If the FIFO is not full, the sample is pushed; otherwise it is dropped and overflow is set.
  - adc_ready = window && !full.
- STREAM pop rule:
  - Pop when the FIFO is not empty and the gap counter is 0.
  - Popped data is registered: eeg and new_eeg_data=1 appear the cycle after the pop.
  - samples_sent increments in the same cycle new_eeg_data is asserted.
  - The gap counter loads GAP_CYCLES on pop and decrements to 0, so successive pulses are >= GAP_CYCLES+1 cycles apart.
- Push and pop in the same cycle:
  - Both are allowed; occupancy is unchanged.
  - A push when full is still dropped, even if a pop occurs that cycle (full is evaluated pre-pop).
  - Push to an empty FIFO is popped no earlier than the next cycle.
- STREAM -> WAIT_INF when in_count == EPOCH_SAMPLES, the FIFO is empty and no output pulse is pending.
  - With overflow set, samples_sent < EPOCH_SAMPLES.
- WAIT_INF:
  - inference_complete -> IDLE.
  - An inference_complete in any other state is ignored.
- epoch_tick in START/STREAM/WAIT_INF: sets epoch_missed; the tick is otherwise ignored and not queued.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.

Optional Feature:
- Macro: EEG_FEED_TIMEOUT_EN.
- Defined:
  - WAIT_INF runs a counter from 0.
  - If it reaches TIMEOUT_CYCLES without inference_complete: timeout=1 and the FSM returns to IDLE.
  - inference_complete in the same cycle as expiry wins (no timeout).
- Undefined:
  - No counter; WAIT_INF waits indefinitely.
  - timeout is tied to 0.

Test Plan:
All scenarios use EPOCH_SAMPLES=8, FIFO_DEPTH=4, GAP_CYCLES=2.
- Nominal:
  - Stimulus: epoch_tick at cycle 10; adc_valid every 5 cycles with data 1..8; inference_complete 20 cycles after the last pulse.
  - Response: start_eeg_load high only in cycle 11; 8 new_eeg_data pulses carrying 1..8 in order; samples_sent=8; busy low after inference_complete.
- Pacing/burst:
  - Stimulus: 4 back-to-back adc_valid right after START.
  - Response: pulses exactly 3 cycles apart; eeg holds between pulses; overflow=0.
- Overflow:
  - Stimulus: 8 back-to-back adc_valid at START.
  - Response: overflow=1; first 4 and any post-pop samples delivered in order; samples_sent<8; FSM still reaches WAIT_INF.
- Spurious events:
  - Stimulus: adc_valid in IDLE; epoch_tick during STREAM; inference_complete during STREAM.
  - Response: IDLE samples never appear; epoch_missed=1; STREAM continues unchanged.
- Reset mid-STREAM:
  - Stimulus: rst_n low after 3 pulses, then release and issue a new epoch_tick.
  - Response: all outputs 0 immediately; FIFO empty; next epoch delivers only post-reset samples.
- Timeout (EEG_FEED_TIMEOUT_EN, TIMEOUT_CYCLES=50):
  - Stimulus: no inference_complete.
  - Response: timeout=1 and IDLE 50 cycles after entering WAIT_INF.
  - Stimulus: inference_complete on cycle 50.
  - Response: timeout=0.

Source files
------------

// File: rtl/eeg_epoch_feeder_if.sv
// Signal bundle between the EEG epoch feeder and its ADC / accelerator neighbours.
// The slave modport is the feeder's view; the master modport is the environment's view.
interface eeg_epoch_feeder_if #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned EPOCH_SAMPLES = 3000
) ();
    localparam int unsigned CNT_W = $clog2(EPOCH_SAMPLES + 1);

    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              adc_ready;
    logic              epoch_tick;
    logic              inference_complete;
    logic              start_eeg_load;
    logic              new_eeg_data;
    logic [DATA_W-1:0] eeg;
    logic              busy;
    logic              overflow;
    logic              epoch_missed;
    logic              timeout;
    logic [CNT_W-1:0]  samples_sent;

    modport slave (
        input  adc_valid, adc_data, epoch_tick, inference_complete,
        output adc_ready, start_eeg_load, new_eeg_data, eeg, busy, overflow,
        output epoch_missed, timeout, samples_sent
    );

    modport master (
        output adc_valid, adc_data, epoch_tick, inference_complete,
        input  adc_ready, start_eeg_load, new_eeg_data, eeg, busy, overflow,
        input  epoch_missed, timeout, samples_sent
    );
endinterface

// File: rtl/eeg_epoch_feeder.sv
// Buffers ADC samples and streams one paced epoch per epoch_tick to the accelerator.
// Optional inference watchdog enabled by defining EEG_FEED_TIMEOUT_EN.
module eeg_epoch_feeder #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned EPOCH_SAMPLES  = 3000,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                clk,
    input logic                rst_n,
    eeg_epoch_feeder_if.slave  io_feed
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(EPOCH_SAMPLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] EPOCH_LAST = CNT_W'(EPOCH_SAMPLES);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {StIdle, StStart, StStream, StWaitInf} state_e;

    state_e            r_state, w_state_next;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_in_count, r_samples_sent;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_eeg;
    logic              r_new_eeg, r_overflow, r_epoch_missed, r_timeout;
    logic              w_full, w_empty, w_start, w_window, w_push, w_pop, w_drop;
    logic              w_timeout_hit;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_start  = (r_state == StStart);
    assign w_window = w_start || ((r_state == StStream) && (r_in_count < EPOCH_LAST));
    assign w_push   = w_window && io_feed.adc_valid && !w_full;
    assign w_drop   = w_window && io_feed.adc_valid && w_full;
    assign w_pop    = (r_state == StStream) && !w_empty && (r_gap == '0);

`ifdef EEG_FEED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != StWaitInf) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // A completion arriving on the expiry cycle takes precedence.
    assign w_timeout_hit = (r_state == StWaitInf) && !io_feed.inference_complete &&
                           (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout_hit    = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (io_feed.epoch_tick) w_state_next = StStart;
            StStart:   w_state_next = StStream;
            StStream:  if ((r_in_count == EPOCH_LAST) && w_empty && !r_new_eeg)
                           w_state_next = StWaitInf;
            StWaitInf: if (io_feed.inference_complete || w_timeout_hit)
                           w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= io_feed.adc_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_in_count     <= '0;
            r_samples_sent <= '0;
            r_gap          <= '0;
            r_eeg          <= '0;
            r_new_eeg      <= 1'b0;
            r_overflow     <= 1'b0;
            r_epoch_missed <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_new_eeg <= w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop) begin
                r_eeg    <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_start) begin
                r_samples_sent <= '0;
                r_gap          <= '0;
                r_overflow     <= 1'b0;
                r_timeout      <= 1'b0;
                r_epoch_missed <= io_feed.epoch_tick;
                r_in_count     <= io_feed.adc_valid ? CNT_W'(1) : '0;
            end else begin
                if (w_window && io_feed.adc_valid) r_in_count <= r_in_count + CNT_W'(1);
                if (w_pop)         r_samples_sent <= r_samples_sent + CNT_W'(1);
                if (w_drop)        r_overflow     <= 1'b1;
                if (w_timeout_hit) r_timeout      <= 1'b1;
                if (io_feed.epoch_tick && (r_state != StIdle)) r_epoch_missed <= 1'b1;
                if (w_pop)               r_gap <= GAP_LOAD;
                else if (r_gap != '0)    r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    assign io_feed.adc_ready      = w_window && !w_full;
    assign io_feed.start_eeg_load = w_start;
    assign io_feed.new_eeg_data   = r_new_eeg;
    assign io_feed.eeg            = r_eeg;
    assign io_feed.busy           = (r_state != StIdle);
    assign io_feed.overflow       = r_overflow;
    assign io_feed.epoch_missed   = r_epoch_missed;
    assign io_feed.timeout        = r_timeout;
    assign io_feed.samples_sent   = r_samples_sent;
endmodule

// File: tb/tb_eeg_epoch_feeder.sv
// Directed bench for eeg_epoch_feeder: a cycle-accurate vector table plus epoch-level sequences.
module tb_eeg_epoch_feeder;
    localparam int DW = 16, DEPTH = 4, EPOCH = 8, GAP = 2, TO = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   errors = 0;
    int   checks = 0;

    eeg_epoch_feeder_if #(.DATA_W(DW), .EPOCH_SAMPLES(EPOCH)) feed ();

    eeg_epoch_feeder #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .EPOCH_SAMPLES(EPOCH),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .io_feed(feed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int            pulse_cyc[$];
    logic [DW-1:0] pulse_val[$];
    int            start_cyc[$];

    always @(negedge clk) begin
        if (feed.new_eeg_data) begin
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(feed.eeg);
        end
        if (feed.start_eeg_load) start_cyc.push_back(cyc);
    end

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          tick;
        logic          inf;
        logic          start;
        logic          nw;
        logic [DW-1:0] eeg;
        logic          busy;
        logic          ready;
        logic [3:0]    ss;
        logic          missed;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic t,
                                input logic i, input logic s, input logic n,
                                input logic [DW-1:0] e, input logic b, input logic r,
                                input logic [3:0] ss, input logic m);
        vec_t x;
        x.valid = v; x.data = d; x.tick = t; x.inf = i; x.start = s; x.nw = n;
        x.eeg = e; x.busy = b; x.ready = r; x.ss = ss; x.missed = m;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        feed.adc_valid = 1'b0;
        feed.adc_data = '0;
        feed.epoch_tick = 1'b0;
        feed.inference_complete = 1'b0;
    endtask

    task automatic pulse_inf();
        feed.inference_complete = 1'b1;
        next_cycle();
        feed.inference_complete = 1'b0;
    endtask

    function automatic logic [31:0] all_outputs();
        return {8'd0, feed.start_eeg_load, feed.new_eeg_data, feed.adc_ready, feed.busy,
                feed.overflow, feed.epoch_missed, feed.timeout, feed.samples_sent, feed.eeg};
    endfunction

    // Tick at cycle tick_at, then nsamp samples first, first+1, ... spaced by `spacing`.
    task automatic drive_epoch(input int tick_at, input logic [DW-1:0] first, input int spacing,
                               input int nsamp, input int ncyc);
        int nxt;
        int sent;
        pulse_cyc.delete();
        pulse_val.delete();
        start_cyc.delete();
        base = cyc;
        sent = 0;
        nxt = tick_at + 1;
        for (int k = 0; k < ncyc; k++) begin
            idle_inputs();
            feed.epoch_tick = (k == tick_at);
            if (sent < nsamp && k == nxt) begin
                feed.adc_valid = 1'b1;
                feed.adc_data = first + DW'(sent);
                sent++;
                nxt += spacing;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic check_pulses(input string name, input logic [DW-1:0] first, input int n);
        check({name, "_count"}, pulse_val.size(), n);
        for (int i = 0; i < n && i < pulse_val.size(); i++)
            check($sformatf("%s_val%0d", name, i), {16'd0, pulse_val[i]}, {16'd0, first + DW'(i)});
    endtask

    function automatic int last_pulse();
        return (pulse_cyc.size() == 0) ? cyc : pulse_cyc[pulse_cyc.size() - 1];
    endfunction

    initial begin
        int p;
        //          valid data  tick inf | start new eeg   busy ready ss missed
        vecs[0]  = mk(1, 'h55, 1, 0,   0, 0, 'h00, 0, 0, 0, 0);
        vecs[1]  = mk(1, 'h11, 0, 0,   1, 0, 'h00, 1, 1, 0, 0);
        vecs[2]  = mk(1, 'h22, 0, 0,   0, 0, 'h00, 1, 1, 0, 0);
        vecs[3]  = mk(1, 'h33, 0, 0,   0, 1, 'h11, 1, 1, 1, 0);
        vecs[4]  = mk(1, 'h44, 0, 0,   0, 0, 'h11, 1, 1, 1, 0);
        vecs[5]  = mk(0, 'h00, 0, 0,   0, 0, 'h11, 1, 1, 1, 0);
        vecs[6]  = mk(0, 'h00, 0, 0,   0, 1, 'h22, 1, 1, 2, 0);
        vecs[7]  = mk(0, 'h00, 1, 0,   0, 0, 'h22, 1, 1, 2, 0);
        vecs[8]  = mk(0, 'h00, 0, 0,   0, 0, 'h22, 1, 1, 2, 1);
        vecs[9]  = mk(0, 'h00, 0, 0,   0, 1, 'h33, 1, 1, 3, 1);
        vecs[10] = mk(0, 'h00, 0, 1,   0, 0, 'h33, 1, 1, 3, 1);
        vecs[11] = mk(0, 'h00, 0, 0,   0, 0, 'h33, 1, 1, 3, 1);
        vecs[12] = mk(0, 'h00, 0, 0,   0, 1, 'h44, 1, 1, 4, 1);
        vecs[13] = mk(1, 'h5A, 0, 0,   0, 0, 'h44, 1, 1, 4, 1);
        vecs[14] = mk(1, 'h6A, 0, 0,   0, 0, 'h44, 1, 1, 4, 1);
        vecs[15] = mk(1, 'h7A, 0, 0,   0, 1, 'h5A, 1, 1, 5, 1);
        vecs[16] = mk(1, 'h8A, 0, 0,   0, 0, 'h5A, 1, 1, 5, 1);
        vecs[17] = mk(0, 'h00, 0, 0,   0, 0, 'h5A, 1, 0, 5, 1);
        vecs[18] = mk(1, 'hEE, 0, 0,   0, 1, 'h6A, 1, 0, 6, 1);
        vecs[19] = mk(0, 'h00, 0, 0,   0, 0, 'h6A, 1, 0, 6, 1);
        vecs[20] = mk(0, 'h00, 0, 0,   0, 0, 'h6A, 1, 0, 6, 1);
        vecs[21] = mk(0, 'h00, 0, 0,   0, 1, 'h7A, 1, 0, 7, 1);
        vecs[22] = mk(0, 'h00, 0, 0,   0, 0, 'h7A, 1, 0, 7, 1);
        vecs[23] = mk(0, 'h00, 0, 0,   0, 0, 'h7A, 1, 0, 7, 1);
        vecs[24] = mk(0, 'h00, 0, 0,   0, 1, 'h8A, 1, 0, 8, 1);
        vecs[25] = mk(0, 'h00, 0, 0,   0, 0, 'h8A, 1, 0, 8, 1);
        vecs[26] = mk(0, 'h00, 0, 1,   0, 0, 'h8A, 1, 0, 8, 1);
        vecs[27] = mk(0, 'h00, 0, 0,   0, 0, 'h8A, 0, 0, 8, 1);

        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Pacing, holding, spurious IDLE sample, tick and completion during STREAM.
        foreach (vecs[i]) begin
            feed.adc_valid = vecs[i].valid;
            feed.adc_data = vecs[i].data;
            feed.epoch_tick = vecs[i].tick;
            feed.inference_complete = vecs[i].inf;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {7'd0, feed.start_eeg_load, feed.new_eeg_data, feed.eeg, feed.busy,
                   feed.adc_ready, feed.samples_sent, feed.epoch_missed},
                  {7'd0, vecs[i].start, vecs[i].nw, vecs[i].eeg, vecs[i].busy,
                   vecs[i].ready, vecs[i].ss, vecs[i].missed});
            @(posedge clk);
            #1;
        end
        idle_inputs();
        check("vec_overflow", feed.overflow, 0);
        repeat (3) next_cycle();

        // Nominal epoch: tick at cycle 10, samples 1..8 every 5 cycles.
        drive_epoch(10, 16'd1, 5, 8, 60);
        check("nom_start_count", start_cyc.size(), 1);
        if (start_cyc.size() > 0) check("nom_start_cycle", start_cyc[0] - base, 11);
        check_pulses("nom", 16'd1, 8);
        check("nom_sent", feed.samples_sent, 8);
        check("nom_missed_cleared", feed.epoch_missed, 0);
        check("nom_busy_waiting", feed.busy, 1);
        p = last_pulse();
        while (cyc < p + 20) next_cycle();
        pulse_inf();
        check("nom_busy_after_inf", feed.busy, 0);
        repeat (3) next_cycle();

        // Overflow: 8 back-to-back samples starting in the START cycle.
        drive_epoch(0, 16'h101, 1, 8, 40);
        check("ovf_flag", feed.overflow, 1);
        check_pulses("ovf", 16'h101, 6);
        check("ovf_sent", feed.samples_sent, 6);
        check("ovf_busy_waiting", feed.busy, 1);
        pulse_inf();
        check("ovf_idle_after_inf", feed.busy, 0);
        repeat (3) next_cycle();

        // Reset mid-STREAM with a sample still buffered.
        drive_epoch(0, 16'h301, 1, 4, 10);
        check("rst_pulses_before", pulse_val.size(), 3);
        rst_n = 1'b0;
        #1;
        check("rst_outputs_immediate", all_outputs(), 32'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();
        drive_epoch(0, 16'h201, 4, 8, 50);
        check_pulses("post_rst", 16'h201, 8);
        check("post_rst_sent", feed.samples_sent, 8);
        p = last_pulse();

`ifdef EEG_FEED_TIMEOUT_EN
        // WAIT_INF is entered two cycles after the last pulse; expiry 50 cycles later.
        while (cyc < p + 51) next_cycle();
        check("to_busy_before", feed.busy, 1);
        next_cycle();
        check("to_expired", {30'd0, feed.busy, feed.timeout}, 32'd1);
        repeat (2) next_cycle();
        drive_epoch(0, 16'h401, 3, 8, 40);
        check_pulses("to2", 16'h401, 8);
        p = last_pulse();
        while (cyc < p + 51) next_cycle();
        check("to2_busy_at_expiry", feed.busy, 1);
        pulse_inf();
        check("to2_inf_wins", {30'd0, feed.busy, feed.timeout}, 32'd0);
`else
        while (cyc < p + 80) next_cycle();
        check("no_to_still_waiting", {30'd0, feed.busy, feed.timeout}, 32'd2);
        pulse_inf();
        check("no_to_idle", feed.busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
